// File: rtl/store_mon_pkg.sv
// store_mon_pkg: shared types, constants and lane-merge helpers for mem_store_monitor.
package store_mon_pkg;
  typedef enum logic [1:0] {MEM_SB = 2'd0, MEM_SH = 2'd1, MEM_SW = 2'd2} mem_op_t;
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} mon_state_t;
  localparam logic [4:0] FAIL_IDX_NONE = 5'h1f;
  function automatic logic [31:0] merge_store(input logic [31:0] old, input mem_op_t op,
                                              input logic [1:0] lo, input logic [31:0] data);
    logic [31:0] w;
    w = old;
    case (op)
      MEM_SB: w[8*lo +: 8] = data[7:0];
      MEM_SH: w[16*lo[1] +: 16] = data[15:0];
      default: w = data;
    endcase
    return w;
  endfunction
  function automatic logic misaligned(input mem_op_t op, input logic [1:0] lo);
    return (op == MEM_SB) ? 1'b0 : (op == MEM_SH) ? lo[0] : |lo;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/store_mon_shadow.sv
// store_mon_shadow: byte-lane-accurate shadow copy of one watched word address.
module store_mon_shadow
  import store_mon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  mem_op_t     op,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [29:0] watch_word,
  output logic [31:0] shadow
);
  logic [31:0] shadow_q, shadow_d;
  always_comb shadow_d = (wr_en && addr[31:2] == watch_word) ? merge_store(shadow_q, op, addr[1:0], data) : shadow_q;
  always_ff @(posedge clk) begin
    if (reset) shadow_q <= '0;
    else shadow_q <= shadow_d;
  end
  assign shadow = shadow_q;
endmodule

// File: rtl/mem_store_monitor.sv
// mem_store_monitor: pass/fail monitor on the data-store bus with per-address shadow compare.
// Optional store history ring buffer enabled by defining MEM_STORE_MONITOR_HIST_EN.
module mem_store_monitor
  import store_mon_pkg::*;
#(
  parameter int          NUM_WATCH      = 4,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0200,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          HIST_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            mem_wr_en,
  input  mem_op_t                         mem_op,
  input  logic [31:0]                     mem_addr,
  input  logic [31:0]                     mem_data_in,
  input  logic [NUM_WATCH-1:0]            watch_en,
  input  logic [NUM_WATCH-1:0][31:0]      watch_addr,
  input  logic [NUM_WATCH-1:0][31:0]      watch_exp,
`ifdef MEM_STORE_MONITOR_HIST_EN
  input  logic [$clog2(HIST_DEPTH)-1:0]   hist_rd_idx,
  output logic [31:0]                     hist_rd_addr,
  output logic [31:0]                     hist_rd_data,
  output logic [HIST_DEPTH-1:0]           hist_valid,
`endif
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            fail,
  output logic                            timed_out,
  output logic [31:0]                     tohost_val,
  output logic [$clog2(NUM_WATCH):0]      fail_idx,
  output logic [31:0]                     cycle_count,
  output logic [31:0]                     store_count
);
  localparam int FW = $clog2(NUM_WATCH) + 1;
  localparam logic [FW-1:0] NONE = FAIL_IDX_NONE[FW-1:0];
  localparam logic [FW-1:0] LAST = FW'(NUM_WATCH - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  mon_state_t state_q, state_d;
  logic [FW-1:0] idx_q, idx_d, fail_idx_q, fail_idx_d;
  logic [31:0] cycle_q, cycle_d, stores_q, stores_d, tohost_q, tohost_d;
  logic timed_out_q, timed_out_d, misalign_q, misalign_d, done_q, done_d, pass_q, pass_d;
  logic run, run_store, mis_store, tohost_st, timeout_hit, cur_mis;
  logic [NUM_WATCH-1:0] mis_vec, unused_lo;
  logic [NUM_WATCH-1:0][31:0] shadow;
  assign run = state_q == RUN;
  assign run_store = run && mem_wr_en;
  assign mis_store = misaligned(mem_op, mem_addr[1:0]);
  assign tohost_st = run_store && mem_addr[31:2] == TOHOST_ADDR[31:2];
  assign timeout_hit = TIMEOUT_CYCLES != 0 && cycle_q == TO_LAST;
  for (genvar i = 0; i < NUM_WATCH; i++) begin : g_w
    store_mon_shadow u_shadow (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (run_store && !mis_store),
      .op         (mem_op),
      .addr       (mem_addr),
      .data       (mem_data_in),
      .watch_word (watch_addr[i][31:2]),
      .shadow     (shadow[i])
    );
    assign mis_vec[i] = watch_en[i] && shadow[i] != watch_exp[i];
    assign unused_lo[i] = ^watch_addr[i][1:0];
  end
  always_comb begin
    cur_mis = 1'b0;
    for (int k = 0; k < NUM_WATCH; k++) if (idx_q == FW'(k)) cur_mis = mis_vec[k];
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fail_idx_d = fail_idx_q;
    cycle_d = cycle_q;
    stores_d = stores_q;
    tohost_d = tohost_q;
    timed_out_d = timed_out_q;
    misalign_d = misalign_q;
    done_d = done_q;
    pass_d = pass_q;
    case (state_q)
      IDLE: state_d = start ? RUN : IDLE;
      RUN: begin
        cycle_d = sat_inc(cycle_q);
        stores_d = mem_wr_en ? sat_inc(stores_q) : stores_q;
        misalign_d = misalign_q || (mem_wr_en && mis_store);
        // a tohost store on the timeout cycle takes precedence
        tohost_d = tohost_st ? merge_store('0, mem_op, mem_addr[1:0], mem_data_in) : tohost_q;
        timed_out_d = !tohost_st && timeout_hit;
        state_d = (tohost_st || timeout_hit) ? CHECK : RUN;
      end
      CHECK: begin
        fail_idx_d = (cur_mis && fail_idx_q == NONE) ? idx_q : fail_idx_q;
        idx_d = idx_q + 1'b1;
        state_d = idx_q == LAST ? DONE : CHECK;
      end
      default: begin
        done_d = 1'b1;
        pass_d = tohost_q == 32'd1 && fail_idx_q == NONE && !misalign_q && !timed_out_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      fail_idx_q <= NONE;
      cycle_q <= '0;
      stores_q <= '0;
      tohost_q <= '0;
      timed_out_q <= 1'b0;
      misalign_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fail_idx_q <= fail_idx_d;
      cycle_q <= cycle_d;
      stores_q <= stores_d;
      tohost_q <= tohost_d;
      timed_out_q <= timed_out_d;
      misalign_q <= misalign_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign busy = state_q == RUN || state_q == CHECK;
  assign done = done_q;
  assign pass = pass_q;
  assign fail = done_q && !pass_q;
  assign timed_out = timed_out_q;
  assign tohost_val = tohost_q;
  assign fail_idx = fail_idx_q;
  assign cycle_count = cycle_q;
  assign store_count = stores_q;
`ifdef MEM_STORE_MONITOR_HIST_EN
  localparam int HW = $clog2(HIST_DEPTH);
  localparam logic [HW:0] HFULL = HIST_DEPTH[HW:0];
  logic [HIST_DEPTH-1:0][65:0] hist_q;
  logic [HW-1:0] wp_q, rd_slot;
  logic [HW:0] hcnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      wp_q <= '0;
      hcnt_q <= '0;
    end else if (run_store) begin
      hist_q[wp_q] <= {mem_addr, mem_data_in, mem_op};
      wp_q <= wp_q + 1'b1;
      hcnt_q <= hcnt_q == HFULL ? hcnt_q : hcnt_q + 1'b1;
    end
  end
  // index 0 is the newest entry, one behind the write pointer
  assign rd_slot = wp_q - 1'b1 - hist_rd_idx;
  assign hist_rd_addr = hist_q[rd_slot][65:34];
  assign hist_rd_data = hist_q[rd_slot][33:2];
  for (genvar h = 0; h < HIST_DEPTH; h++) begin : g_hv
    assign hist_valid[h] = hcnt_q > h;
  end
`else
`endif
endmodule

// File: tb/tb_mem_store_monitor.sv
// tb_mem_store_monitor: scoreboard bench; expected end-of-test results are queued, a monitor checks them on done.
module tb_mem_store_monitor;
  import store_mon_pkg::*;
  localparam int N = 4;
  localparam logic [2:0] NONE = 3'h7;
  typedef struct {
    int id;
    logic ps;
    logic to;
    logic [2:0] fi;
    logic [31:0] tv;
    bit ctv;
    logic [31:0] cc;
    int dc;
  } exp_t;
  logic clk = 0, reset = 1, start = 0, mem_wr_en = 0;
  mem_op_t mem_op = MEM_SW;
  logic [31:0] mem_addr = '0, mem_data_in = '0;
  logic [N-1:0] watch_en = '0;
  logic [N-1:0][31:0] watch_addr = '0, watch_exp = '0;
  logic busy, done, pass, fail, timed_out;
  logic [31:0] tohost_val, cycle_count, store_count;
  logic [2:0] fail_idx;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  exp_t m_e;
  bit seen = 0;

  mem_store_monitor #(.NUM_WATCH(N), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_wr_en(mem_wr_en), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .watch_en(watch_en),
    .watch_addr(watch_addr), .watch_exp(watch_exp), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .timed_out(timed_out), .tohost_val(tohost_val),
    .fail_idx(fail_idx), .cycle_count(cycle_count), .store_count(store_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) seen = 0;
    else if (!seen) begin
      seen = 1;
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        m_e = q.pop_front();
        $display("case %0d end-of-test check", m_e.id);
        chk("latency", cyc, m_e.dc);
        chk("pass", {31'd0, pass}, {31'd0, m_e.ps});
        chk("fail", {31'd0, fail}, {31'd0, !m_e.ps});
        chk("timed_out", {31'd0, timed_out}, {31'd0, m_e.to});
        chk("fail_idx", {29'd0, fail_idx}, {29'd0, m_e.fi});
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("cycle_count", cycle_count, m_e.cc);
        if (m_e.ctv) chk("tohost_val", tohost_val, m_e.tv);
      end
    end
  end

  task automatic setw(input int i, input bit en, input logic [31:0] a, input logic [31:0] e);
    watch_en[i] = en;
    watch_addr[i] = a;
    watch_exp[i] = e;
  endtask

  task automatic clr_w();
    for (int i = 0; i < N; i++) setw(i, 1'b0, 32'h300 + 32'(16 * i), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1;
    start = 0;
    mem_wr_en = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic chk_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);
    chk("rst_timed_out", {31'd0, timed_out}, 32'd0);
    chk("rst_tohost_val", tohost_val, 32'd0);
    chk("rst_fail_idx", {29'd0, fail_idx}, {29'd0, NONE});
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_store_count", store_count, 32'd0);
  endtask

  task automatic go();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic st(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    mem_op = op;
    mem_addr = a;
    mem_data_in = d;
    mem_wr_en = 1;
    @(negedge clk);
    mem_wr_en = 0;
  endtask

  task automatic push(input int id, input logic ps, input logic to, input logic [2:0] fi,
                      input logic [31:0] tv, input bit ctv, input logic [31:0] cc, input int dc);
    exp_t e;
    e.id = id; e.ps = ps; e.to = to; e.fi = fi; e.tv = tv; e.ctv = ctv; e.cc = cc; e.dc = dc;
    q.push_back(e);
  endtask

  task automatic wait_q(input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic end_run(input int id, input logic ps, input logic to, input logic [2:0] fi,
                         input logic [31:0] tv, input bit ctv, input logic [31:0] cc,
                         input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    push(id, ps, to, fi, tv, ctv, cc, cyc + N + 2);
    st(op, a, d);
    wait_q(40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clr_w();
    do_reset();
    chk_reset();
    // 1: word store then tohost 1
    setw(0, 1, 32'h204, 32'h0000_000A);
    go();
    chk("busy_run", {31'd0, busy}, 32'd1);
    st(MEM_SW, 32'h204, 32'h0A);
    end_run(1, 1, 0, NONE, 32'd1, 1, 32'd2, MEM_SW, 32'h200, 32'd1);
    chk("store_count", store_count, 32'd2);
    st(MEM_SW, 32'h300, 32'd5);
    chk("store_in_done_ignored", store_count, 32'd2);
    // 2: byte lanes
    do_reset(); clr_w();
    setw(0, 1, 32'h204, 32'h0000_2211);
    go();
    st(MEM_SB, 32'h204, 32'h11);
    st(MEM_SB, 32'h205, 32'h22);
    end_run(2, 1, 0, NONE, 32'd1, 1, 32'd3, MEM_SW, 32'h200, 32'd1);
    // 2b: half merge, duplicate watch, upper byte lane
    do_reset(); clr_w();
    setw(0, 1, 32'h204, 32'hBEEF_2211);
    setw(1, 1, 32'h207, 32'hBEEF_2211);
    setw(2, 1, 32'h208, 32'h7700_0000);
    go();
    st(MEM_SB, 32'h204, 32'h11);
    st(MEM_SB, 32'h205, 32'h22);
    st(MEM_SH, 32'h206, 32'hBEEF);
    st(MEM_SB, 32'h20B, 32'hFFFF_FF77);
    end_run(3, 1, 0, NONE, 32'd1, 1, 32'd5, MEM_SW, 32'h200, 32'd1);
    // 3: tohost value 3 fails
    do_reset(); clr_w();
    go();
    end_run(4, 0, 0, NONE, 32'd3, 1, 32'd1, MEM_SW, 32'h200, 32'd3);
    // 4: timeout after 50 RUN cycles
    do_reset(); clr_w();
    push(5, 0, 1, NONE, 32'd0, 1, 32'd50, cyc + 56);
    go();
    wait_q(120);
    // 4b: tohost on cycle 49 beats timeout
    do_reset(); clr_w();
    go();
    repeat (49) @(negedge clk);
    chk("cycle_count_49", cycle_count, 32'd49);
    end_run(6, 1, 0, NONE, 32'd1, 1, 32'd50, MEM_SW, 32'h200, 32'd1);
    // 5: first enabled mismatch latched
    do_reset(); clr_w();
    setw(0, 1, 32'h218, 32'h0);
    setw(2, 1, 32'h210, 32'h5);
    setw(3, 1, 32'h214, 32'h9);
    go();
    st(MEM_SW, 32'h210, 32'h6);
    st(MEM_SW, 32'h214, 32'h1);
    end_run(7, 0, 0, 3'd2, 32'd1, 1, 32'd3, MEM_SW, 32'h200, 32'd1);
    do_reset();
    setw(2, 0, 32'h210, 32'h5);
    go();
    st(MEM_SW, 32'h210, 32'h6);
    st(MEM_SW, 32'h214, 32'h1);
    end_run(8, 0, 0, 3'd3, 32'd1, 1, 32'd3, MEM_SW, 32'h200, 32'd1);
    // 6: reset during CHECK cycle 1
    do_reset(); clr_w();
    go();
    st(MEM_SW, 32'h200, 32'd1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk_reset();
    reset = 0;
    repeat (8) @(negedge clk);
    chk("no_done_after_reset", {31'd0, done}, 32'd0);
    // 6b: misaligned half on tohost word, then start ignored in DONE
    do_reset(); clr_w();
    go();
    end_run(9, 0, 0, NONE, 32'd0, 0, 32'd1, MEM_SH, 32'h201, 32'hBEEF);
    go();
    repeat (3) @(negedge clk);
    chk("start_ignored_busy", {31'd0, busy}, 32'd0);
    chk("start_ignored_done", {31'd0, done}, 32'd1);
    chk("start_ignored_cc", cycle_count, 32'd1);
    // 7: misaligned half leaves shadow untouched, still fails
    do_reset(); clr_w();
    setw(0, 1, 32'h204, 32'h0);
    go();
    st(MEM_SH, 32'h205, 32'hFFFF);
    end_run(10, 0, 0, NONE, 32'd1, 1, 32'd2, MEM_SW, 32'h200, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
